// File: rtl/stream_blur3x3.sv
// Streaming 3x3 low-pass filter (bypass / box mean / optional 1-2-1 Gaussian) over packed pixels.
// Define STREAM_BLUR_GAUSS_EN to build the Gaussian datapath; without it mode 2 behaves as box.
module stream_blur3x3 #(
    parameter int IMG_WIDTH = 640,
    parameter int CH_BITS   = 4,
    parameter int CHANNELS  = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic                        in_sof,
    input  logic [CH_BITS*CHANNELS-1:0] in_pixel,
    input  logic [1:0]                  mode,
    output logic                        out_valid,
    output logic                        out_sof,
    output logic                        out_eol,
    output logic [CH_BITS*CHANNELS-1:0] out_pixel,
    output logic                        dbg_synced
);
    localparam int PW = CH_BITS * CHANNELS;
    localparam int SW = CH_BITS + 4;
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);

    // Valid-only stream, no ready: a pixel transfers on every cycle in_valid is high,
    // and out_valid is a one-cycle strobe per result; data and flags hold between strobes.
    typedef enum logic {ST_UNSYNC = 1'b0, ST_SYNC = 1'b1} state_t;
    state_t state_q, state_d;

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [1:0]    row_q, row_d, cur_row;
    logic          first_q, first_d;
    logic          accept, emit;

    logic [PW-1:0] lb1_mem [0:IMG_WIDTH-1];
    logic [PW-1:0] lb2_mem [0:IMG_WIDTH-1];
    logic [PW-1:0] top_px, mid_px;
    logic [PW-1:0] w1_t_q, w1_m_q, w1_b_q, w2_t_q, w2_m_q, w2_b_q;

    logic                 v1_q, sof1_q, eol1_q;
    logic [1:0]           mode1_q;
    logic [CHANNELS*SW-1:0] box_d, box1_q;
    logic [PW-1:0]        ctr1_q;
`ifdef STREAM_BLUR_GAUSS_EN
    logic [CHANNELS*SW-1:0] gau_d, gau1_q;
`endif
    logic [PW-1:0]        pix_d;
    logic                 out_valid_q, out_sof_q, out_eol_q;
    logic [PW-1:0]        out_pixel_q;

    function automatic logic [SW-1:0] chx(input logic [PW-1:0] p, input int ch);
        return SW'(p[ch*CH_BITS +: CH_BITS]);
    endfunction

    function automatic logic [CH_BITS-1:0] box_div(input logic [SW-1:0] s);
        return CH_BITS'((s + SW'(4)) / SW'(9));
    endfunction

`ifdef STREAM_BLUR_GAUSS_EN
    function automatic logic [CH_BITS-1:0] gau_shr(input logic [SW-1:0] g);
        return CH_BITS'((g + SW'(8)) >> 4);
    endfunction
`endif

    // in_sof overrides the running counters, so a new frame can start anywhere.
    assign cur_col = in_sof ? '0 : col_q;
    assign cur_row = in_sof ? '0 : row_q;
    assign top_px  = lb2_mem[cur_col];
    assign mid_px  = lb1_mem[cur_col];
    assign emit    = accept && (cur_col >= CW'(2)) && (cur_row == 2'd2);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        col_d   = col_q;
        row_d   = row_q;
        first_d = first_q;
        if (in_valid && (state_q == ST_SYNC || in_sof)) accept = 1'b1;
        if (in_valid && in_sof) state_d = ST_SYNC;
        if (accept) begin
            if (cur_col == LAST_COL) begin
                col_d = '0;
                row_d = (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
            if (in_sof) first_d = 1'b1;
            else if (emit) first_d = 1'b0;
        end
    end

    // Window columns: w1 = column c-1, w2 = column c-2; column c comes straight from the buffers.
    always_comb begin
        box_d = '0;
`ifdef STREAM_BLUR_GAUSS_EN
        gau_d = '0;
`endif
        for (int ch = 0; ch < CHANNELS; ch++) begin
            box_d[ch*SW +: SW] = chx(w2_t_q, ch) + chx(w2_m_q, ch) + chx(w2_b_q, ch)
                               + chx(w1_t_q, ch) + chx(w1_m_q, ch) + chx(w1_b_q, ch)
                               + chx(top_px, ch) + chx(mid_px, ch) + chx(in_pixel, ch);
`ifdef STREAM_BLUR_GAUSS_EN
            gau_d[ch*SW +: SW] = chx(w2_t_q, ch) + chx(w2_b_q, ch) + chx(top_px, ch) + chx(in_pixel, ch)
                               + ((chx(w2_m_q, ch) + chx(w1_t_q, ch) + chx(w1_b_q, ch) + chx(mid_px, ch)) << 1)
                               + (chx(w1_m_q, ch) << 2);
`endif
        end
    end

    always_comb begin
        pix_d = out_pixel_q;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            case (mode1_q)
                2'd0:    pix_d[ch*CH_BITS +: CH_BITS] = ctr1_q[ch*CH_BITS +: CH_BITS];
`ifdef STREAM_BLUR_GAUSS_EN
                2'd2:    pix_d[ch*CH_BITS +: CH_BITS] = gau_shr(gau1_q[ch*SW +: SW]);
`endif
                default: pix_d[ch*CH_BITS +: CH_BITS] = box_div(box1_q[ch*SW +: SW]);
            endcase
        end
    end

    // Line buffers and window carry pure data and are never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2_mem[cur_col] <= lb1_mem[cur_col];
            lb1_mem[cur_col] <= in_pixel;
            w2_t_q <= w1_t_q;
            w2_m_q <= w1_m_q;
            w2_b_q <= w1_b_q;
            w1_t_q <= top_px;
            w1_m_q <= mid_px;
            w1_b_q <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_UNSYNC;
            col_q       <= '0;
            row_q       <= '0;
            first_q     <= 1'b0;
            v1_q        <= 1'b0;
            sof1_q      <= 1'b0;
            eol1_q      <= 1'b0;
            mode1_q     <= 2'd0;
            box1_q      <= '0;
            ctr1_q      <= '0;
`ifdef STREAM_BLUR_GAUSS_EN
            gau1_q      <= '0;
`endif
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_pixel_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            first_q     <= first_d;
            v1_q        <= emit;
            if (emit) begin
                sof1_q  <= first_q;
                eol1_q  <= (cur_col == LAST_COL);
                mode1_q <= mode;
                box1_q  <= box_d;
                ctr1_q  <= w1_m_q;
`ifdef STREAM_BLUR_GAUSS_EN
                gau1_q  <= gau_d;
`endif
            end
            out_valid_q <= v1_q;
            if (v1_q) begin
                out_sof_q   <= sof1_q;
                out_eol_q   <= eol1_q;
                out_pixel_q <= pix_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sof    = out_sof_q;
    assign out_eol    = out_eol_q;
    assign out_pixel  = out_pixel_q;
    assign dbg_synced = (state_q == ST_SYNC);
endmodule

// File: tb/tb_stream_blur3x3.sv
// Bench for stream_blur3x3 at 8 pixels per line, 4-bit x 3 channels; expected results go into a
// timestamped queue and a negedge monitor pops one entry per out_valid strobe.
module tb_stream_blur3x3;
    localparam int W  = 8;
    localparam int PW = 12;
    localparam int EW = 32 + 2 + PW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_sof;
    logic [PW-1:0] in_pixel;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_sof;
    logic          out_eol;
    logic [PW-1:0] out_pixel;
    logic          dbg_synced;

    int unsigned   cyc = 0;
    logic [EW-1:0] exp_q[$];
    int            checks = 0;
    int            failures = 0;

    stream_blur3x3 #(.IMG_WIDTH(W), .CH_BITS(4), .CHANNELS(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_pixel(in_pixel), .mode(mode), .out_valid(out_valid), .out_sof(out_sof),
        .out_eol(out_eol), .out_pixel(out_pixel), .dbg_synced(dbg_synced)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: bench still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

    // input frame patterns
    function automatic logic [PW-1:0] pix_of(input int kind, input int c, input int r, input logic [PW-1:0] uni);
        case (kind)
            0:       return uni;
            1, 2:    return (c == 3 && r == 2) ? 12'hFFF : 12'h000;
            default: return {4'(r), 4'(c), 4'hA};
        endcase
    endfunction

    // expected filtered value for centre (cx, cy)
    function automatic logic [PW-1:0] exp_of(input int kind, input int cx, input int cy, input logic [PW-1:0] uni);
        int dx;
        int dy;
        dx = (cx > 3) ? cx - 3 : 3 - cx;
        dy = (cy > 2) ? cy - 2 : 2 - cy;
        case (kind)
            0: return uni;
            1: return (dx <= 1 && dy <= 1) ? 12'h222 : 12'h000;
            2: begin
`ifdef STREAM_BLUR_GAUSS_EN
                if (dx > 1 || dy > 1) return 12'h000;
                else if (dx + dy == 0) return 12'h444;
                else if (dx + dy == 1) return 12'h222;
                else return 12'h111;
`else
                return (dx <= 1 && dy <= 1) ? 12'h222 : 12'h000;
`endif
            end
            default: return pix_of(3, cx, cy, uni);
        endcase
    endfunction

    // driver tasks
    task automatic drive(input logic v, input logic sof, input logic [PW-1:0] px, input logic [1:0] md);
        in_valid = v;
        in_sof   = sof;
        in_pixel = px;
        mode     = md;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int kind, input int rows, input int stop_r, input int stop_c,
                              input logic [1:0] md, input int gaps, input logic with_sof,
                              input logic expect_out, input logic [PW-1:0] uni);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                if (expect_out && c >= 2 && r >= 2)
                    exp_q.push_back({32'(cyc + 2), (c == 2 && r == 2), (c == W - 1),
                                     exp_of(kind, c - 1, r - 1, uni)});
                drive(1'b1, with_sof && r == 0 && c == 0, pix_of(kind, c, r, uni), md);
                for (int g = 0; g < gaps; g++) drive(1'b0, 1'b1, 12'h5A5, md);
            end
        end
        drive(1'b0, 1'b0, 12'h000, md);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 8; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EW-1:0] act;
        logic [EW-1:0] req;
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            act = {32'(cyc), out_sof, out_eol, out_pixel};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected: got cyc=%0d sof=%0b eol=%0b pix=%h, required no output",
                         act[EW-1:14], act[13], act[12], act[11:0]);
            end else begin
                req = exp_q.pop_front();
                if (act !== req) begin
                    failures++;
                    $display("FAIL out_beat: got cyc=%0d sof=%0b eol=%0b pix=%h, required cyc=%0d sof=%0b eol=%0b pix=%h",
                             act[EW-1:14], act[13], act[12], act[11:0],
                             req[EW-1:14], req[13], req[12], req[11:0]);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = '0;
        mode     = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_sof", 32'(out_sof), 32'd0);
        check("reset_out_eol", 32'(out_eol), 32'd0);
        check("reset_out_pixel", 32'(out_pixel), 32'd0);
        check("reset_unsynced", 32'(dbg_synced), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // uniform frame, box
        send_frame(0, 5, -1, -1, 2'd1, 0, 1'b1, 1'b1, 12'h888);
        wait_drain("drain_uniform");
        // impulse, box then Gaussian/box
        send_frame(1, 5, -1, -1, 2'd1, 0, 1'b1, 1'b1, 12'h000);
        wait_drain("drain_impulse_box");
        send_frame(2, 5, -1, -1, 2'd2, 0, 1'b1, 1'b1, 12'h000);
        wait_drain("drain_impulse_gauss");
        // bypass ramp with 1-0-0-1 valid pattern; idle beats carry an unqualified in_sof
        send_frame(3, 4, -1, -1, 2'd0, 2, 1'b1, 1'b1, 12'h000);
        wait_drain("drain_bypass_gaps");

        // resync mid-line 2, new frame of a different value, mode 3
        send_frame(0, 5, 2, 4, 2'd3, 0, 1'b1, 1'b1, 12'h777);
        send_frame(0, 3, -1, -1, 2'd3, 0, 1'b1, 1'b1, 12'h333);
        wait_drain("drain_resync");

        // reset with two results in flight
        send_frame(0, 5, 2, 5, 2'd1, 0, 1'b1, 1'b1, 12'h555);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_out_sof", 32'(out_sof), 32'd0);
        check("midreset_out_pixel", 32'(out_pixel), 32'd0);
        check("midreset_unsynced", 32'(dbg_synced), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(0, 3, -1, -1, 2'd1, 0, 1'b0, 1'b0, 12'h999);
        check("presync_ignored", 32'(dbg_synced), 32'd0);
        send_frame(0, 3, -1, -1, 2'd1, 0, 1'b1, 1'b1, 12'h555);
        wait_drain("drain_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
